cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter HW_IRQ_N, default 5: number of external interrupt lines; legal range 1..5; mapped to Cause.IP[2+HW_IRQ_N-1:2].
REQ-002 Parameter TIMER_DIV, default 2: Count increments once every TIMER_DIV clocks; legal range 1..256.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 mtc0_we  in  1  register write strobe.
REQ-007 waddr  in  5  write register number.
REQ-008 wdata  in  32  write data.
REQ-009 raddr  in  5  read register number.
REQ-010 rdata  out  32  combinational read data.
REQ-011 exc_valid  in  1  exception commit strobe.
REQ-012 exc_code  in  5  ExcCode for Cause[6:2].
REQ-013 exc_pc  in  32  PC of faulting instruction.
REQ-014 exc_bd  in  1  faulting instruction sits in a delay slot.
REQ-015 exc_badvaddr  in  32  faulting address.
REQ-016 eret  in  1  exception-return strobe.
REQ-017 hw_int  in  HW_IRQ_N  level-sensitive external interrupt lines.
REQ-018 epc_out  out  32  current EPC, the eret target.
REQ-019 status_exl  out  1  Status.EXL.
REQ-020 int_req  out  1  registered interrupt request to the pipeline.

Function
REQ-021 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); every other address shall read 0 and ignore writes.
REQ-022 rdata shall reflect register state before the current edge, so a read of an address written in the same cycle returns the old value.
REQ-023 Status writes: only IM[15:8], EXL[1], and IE[0] are writable; BEV[22] shall read constant 1; all other bits read 0.
REQ-024 Cause writes: only IP[9:8] (software interrupts) are writable; all other bits shall hold their value.
REQ-025 Prescaler: a counter 0..TIMER_DIV-1 increments every clock; on wrap, Count increments by 1, with 32-bit wrap-around 0xFFFFFFFF->0.
REQ-026 An mtc0 to Count shall load wdata and clear the prescaler; no increment occurs in that cycle.
REQ-027 Timer match: when Count increments to a value equal to Compare, Cause.TI[30] and Cause.IP[7] shall be set on that edge and held.
REQ-028 An mtc0 to Compare shall clear TI and IP[7] on the same edge; if a match occurs on that same edge, the clear wins.
REQ-029 Cause.IP[2+HW_IRQ_N-1:2] shall be sampled from hw_int every clock with one cycle of latency; unused IP bits read 0.
REQ-030 int_req shall be registered as Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]), with one cycle of latency from the register state.
REQ-031 Exception handling when exc_valid=1 and EXL=0: set EXL; Cause.BD[31]=exc_bd; EPC = exc_bd ? exc_pc-4 : exc_pc; Cause.ExcCode = exc_code.
REQ-032 Exception handling when exc_valid=1 and EXL=1: update ExcCode only; leave EPC and BD unchanged.
REQ-033 BadVAddr shall load exc_badvaddr on exc_valid only when exc_code is 4 (AdEL) or 5 (AdES).
REQ-034 eret shall clear EXL on the next edge; epc_out is valid in the same cycle.
REQ-035 Simultaneous strobes: priority is exc_valid > eret > mtc0_we; the losing strobes are ignored for that cycle.
REQ-036 The Count and prescaler advance shall continue during exception and eret cycles.
REQ-037 The hw_int sampling and timer match shall continue during exception and eret cycles.

Reset
REQ-038 On rst: all registers 0 except Status=0x0040_0000, prescaler=0, int_req=0, status_exl=0.
REQ-039 Reset asserted mid-operation shall abort any pending match or interrupt immediately, without waiting for a clock edge.

Verification
REQ-040 TIMER_DIV=2, Compare=5, Count=0 -> Count reaches 5 after 10 clocks, TI=1; with IE=1 and IM[7]=1, int_req=1 one clock later; mtc0 Compare -> TI=0.
REQ-041 exc_valid, exc_bd=1, exc_pc=0xBFC0_0104, exc_code=4, badvaddr=0x1233 -> EPC=0xBFC0_0100, BD=1, BadVAddr=0x1233, EXL=1.
REQ-042 Second exc_valid while EXL=1 with exc_code=0x0A -> ExcCode=0x0A, EPC unchanged; eret -> EXL=0.
REQ-043 mtc0 Status=0xFFFF_FFFF -> reads 0x0040_FF03; mtc0 Cause=0xFFFF_FFFF -> only IP[9:8] set; software interrupt asserts int_req after EXL clears.
REQ-044 exc_valid, eret, and mtc0 Count in the same cycle -> only the exception takes effect, Count keeps counting; Count=0xFFFF_FFFF wraps to 0.
REQ-045 hw_int[0] pulse -> IP[2] follows one cycle later; rst asserted mid-count -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 register file with exception entry/return, a
// prescaled Count/Compare timer, and a registered interrupt request.
module cp0_unit #(
   parameter int HW_IRQ_N  = 5,
   parameter int TIMER_DIV = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mtc0_we,
   input  logic [4:0]          waddr,
   input  logic [31:0]         wdata,
   input  logic [4:0]          raddr,
   output logic [31:0]         rdata,
   input  logic                exc_valid,
   input  logic [4:0]          exc_code,
   input  logic [31:0]         exc_pc,
   input  logic                exc_bd,
   input  logic [31:0]         exc_badvaddr,
   input  logic                eret,
   input  logic [HW_IRQ_N-1:0] hw_int,
   output logic [31:0]         epc_out,
   output logic                status_exl,
   output logic                int_req
);

   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] EXC_ADEL     = 5'd4;
   localparam logic [4:0] EXC_ADES     = 5'd5;

   logic [31:0]         badvaddr_q, badvaddr_d;
   logic [31:0]         count_q, count_d;
   logic [31:0]         compare_q, compare_d;
   logic [31:0]         epc_q, epc_d;
   logic [7:0]          im_q, im_d;
   logic                exl_q, exl_d;
   logic                ie_q, ie_d;
   logic                bd_q, bd_d;
   logic                ti_q, ti_d;
   logic [1:0]          ip_sw_q, ip_sw_d;
   logic [HW_IRQ_N-1:0] ip_hw_q;
   logic [4:0]          exccode_q, exccode_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                int_req_q, int_req_d;

   logic [4:0]  hw_ip_s;
   logic [7:0]  ip_s;
   logic [31:0] status_s;
   logic [31:0] cause_s;
   logic [31:0] count_inc_s;
   logic        tick_s;
   logic        wr_s;
   logic        cnt_wr_s;
   logic        cmp_wr_s;
   logic        match_s;

   // Widen the sampled hardware lines to the full five IP slots; unused slots read 0
   always_comb begin
      hw_ip_s = 5'b0;
      hw_ip_s[HW_IRQ_N-1:0] = ip_hw_q;
   end

   // IP[7] is the timer interrupt and always mirrors TI
   assign ip_s     = {ti_q, hw_ip_s, ip_sw_q};
   assign status_s = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_s  = {bd_q, ti_q, 14'b0, ip_s, 1'b0, exccode_q, 2'b0};

   // mtc0 only takes effect when neither an exception nor an eret claims the cycle
   assign wr_s        = mtc0_we & ~exc_valid & ~eret;
   assign cnt_wr_s    = wr_s & (waddr == REG_COUNT);
   assign cmp_wr_s    = wr_s & (waddr == REG_COMPARE);
   assign tick_s      = (presc_q == PRESC_MAX);
   assign count_inc_s = count_q + 32'd1;
   // A match needs a real increment; a Count load never matches on its own edge
   assign match_s     = tick_s & ~cnt_wr_s & (count_inc_s == compare_q);

   // Next-state logic for timer, exception entry/return and software writes
   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      presc_d    = presc_q;

      if (cnt_wr_s) begin
         count_d = wdata;
         presc_d = PW'(0);
      end else if (tick_s) begin
         count_d = count_inc_s;
         presc_d = PW'(0);
      end else begin
         presc_d = presc_q + PW'(1);
      end

      // A Compare write acknowledges the timer and beats a same-edge match
      if (cmp_wr_s) begin
         ti_d = 1'b0;
      end else if (match_s) begin
         ti_d = 1'b1;
      end else begin
         ti_d = ti_q;
      end

      if (exc_valid) begin
         // Nested exceptions keep the original EPC/BD so the outer handler can return
         if (!exl_q) begin
            exl_d = 1'b1;
            bd_d  = exc_bd;
            epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
         end else begin
            exl_d = exl_q;
         end
         exccode_d = exc_code;
         if ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES)) begin
            badvaddr_d = exc_badvaddr;
         end else begin
            badvaddr_d = badvaddr_q;
         end
      end else if (eret) begin
         exl_d = 1'b0;
      end else if (mtc0_we) begin
         // Count is handled with the prescaler; BadVAddr is read-only
         case (waddr)
            REG_COMPARE: compare_d = wdata;
            REG_STATUS: begin
               im_d  = wdata[15:8];
               exl_d = wdata[1];
               ie_d  = wdata[0];
            end
            REG_CAUSE:   ip_sw_d = wdata[9:8];
            REG_EPC:     epc_d   = wdata;
            default:     compare_d = compare_q;
         endcase
      end else begin
         exl_d = exl_q;
      end
   end

   // Interrupt request derived from the current register state, registered below
   always_comb begin
      int_req_d = ie_q & ~exl_q & (|(ip_s & im_q));
   end

   // Architectural state; reset clears everything asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         badvaddr_q <= 32'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         epc_q      <= 32'd0;
         im_q       <= 8'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= 2'd0;
         ip_hw_q    <= '0;
         exccode_q  <= 5'd0;
         presc_q    <= PW'(0);
         int_req_q  <= 1'b0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_sw_q    <= ip_sw_d;
         ip_hw_q    <= hw_int;
         exccode_q  <= exccode_d;
         presc_q    <= presc_d;
         int_req_q  <= int_req_d;
      end
   end

   // Read mux shows pre-edge state, so same-cycle writes are not visible
   always_comb begin
      case (raddr)
         REG_BADVADDR: rdata = badvaddr_q;
         REG_COUNT:    rdata = count_q;
         REG_COMPARE:  rdata = compare_q;
         REG_STATUS:   rdata = status_s;
         REG_CAUSE:    rdata = cause_s;
         REG_EPC:      rdata = epc_q;
         default:      rdata = 32'd0;
      endcase
   end

   assign epc_out    = epc_q;
   assign status_exl = exl_q;
   assign int_req    = int_req_q;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenarios plus a randomized run against a
// register-level behavioural model of coprocessor 0.
module tb_cp0_unit;

   localparam int HW_N = 5;
   localparam int TDIV = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            mtc0_we;
   logic [4:0]      waddr;
   logic [31:0]     wdata;
   logic [4:0]      raddr;
   logic [31:0]     rdata;
   logic            exc_valid;
   logic [4:0]      exc_code;
   logic [31:0]     exc_pc;
   logic            exc_bd;
   logic [31:0]     exc_badvaddr;
   logic            eret;
   logic [HW_N-1:0] hw_int;
   logic [31:0]     epc_out;
   logic            status_exl;
   logic            int_req;

   int vectors     = 0;
   int miscompares = 0;

   // Model: whole 32-bit register images, updated with masks
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badv;
   int          m_presc;
   logic        m_int;

   cp0_unit #(.HW_IRQ_N(HW_N), .TIMER_DIV(TDIV)) dut (
      .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
      .hw_int(hw_int), .epc_out(epc_out), .status_exl(status_exl), .int_req(int_req)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_count = 32'd0; m_compare = 32'd0; m_status = 32'h0040_0000;
      m_cause = 32'd0; m_epc = 32'd0; m_badv = 32'd0; m_presc = 0; m_int = 1'b0;
   endtask

   task automatic idle();
      mtc0_we = 1'b0; waddr = 5'd0; wdata = 32'd0; exc_valid = 1'b0; exc_code = 5'd0;
      exc_pc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0; eret = 1'b0;
   endtask

   // Apply one clock edge to both the model and the DUT (inputs already driven)
   task automatic step();
      logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_badv;
      int          n_presc;
      logic        n_int, wr;
      n_count = m_count; n_compare = m_compare; n_status = m_status;
      n_cause = m_cause; n_epc = m_epc; n_badv = m_badv; n_presc = m_presc;
      wr = mtc0_we && !exc_valid && !eret;
      if (wr && waddr == 5'd9) begin
         n_count = wdata; n_presc = 0;
      end else if (m_presc == TDIV - 1) begin
         n_presc = 0;
         n_count = m_count + 32'd1;
         if (n_count == m_compare) n_cause = n_cause | 32'h4000_8000;
      end else begin
         n_presc = m_presc + 1;
      end
      if (wr && waddr == 5'd11) begin
         n_compare = wdata;
         n_cause   = n_cause & ~32'h4000_8000;
      end
      n_cause = (n_cause & ~32'h0000_7C00) | ({27'd0, hw_int} << 10);
      n_int = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
      if (exc_valid) begin
         if (!m_status[1]) begin
            n_status  = n_status | 32'h0000_0002;
            n_cause[31] = exc_bd;
            n_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
         end
         n_cause[6:2] = exc_code;
         if (exc_code == 5'd4 || exc_code == 5'd5) n_badv = exc_badvaddr;
      end else if (eret) begin
         n_status = n_status & ~32'h0000_0002;
      end else if (mtc0_we) begin
         case (waddr)
            5'd12:   n_status = 32'h0040_0000 | (wdata & 32'h0000_FF03);
            5'd13:   n_cause  = (n_cause & ~32'h0000_0300) | (wdata & 32'h0000_0300);
            5'd14:   n_epc    = wdata;
            default: ;
         endcase
      end
      @(posedge clk);
      m_count = n_count; m_compare = n_compare; m_status = n_status; m_cause = n_cause;
      m_epc = n_epc; m_badv = n_badv; m_presc = n_presc; m_int = n_int;
      #1;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      idle(); mtc0_we = 1'b1; waddr = a; wdata = d;
      step();
      idle();
   endtask

   task automatic test_reset();
      logic [31:0] rv;
      rst = 1'b1; idle(); raddr = 5'd0; hw_int = '0;
      #23; rst = 1'b0; model_reset(); #2;
      for (int a = 0; a < 32; a++) begin
         raddr = a[4:0]; #1;
         rv = (a == 12) ? 32'h0040_0000 : 32'd0;
         vectors++;
         if (rdata !== rv) begin miscompares++; $display("FAIL reset_rdata[%0d] got %h exp %h", a, rdata, rv); end
      end
      vectors++;
      if ({int_req, status_exl, epc_out} !== 34'd0) begin
         miscompares++; $display("FAIL reset_outputs got %b %b %h exp 0 0 0", int_req, status_exl, epc_out);
      end
   endtask

   task automatic test_timer();
      wr_reg(5'd11, 32'd5);
      wr_reg(5'd12, 32'h0000_8001);
      wr_reg(5'd9, 32'd0);
      raddr = 5'd9;
      for (int i = 0; i < 9; i++) step();
      vectors++;
      if (rdata !== 32'd4) begin miscompares++; $display("FAIL timer_count9 got %h exp 4", rdata); end
      raddr = 5'd13; #1;
      vectors++;
      if (rdata[30] !== 1'b0) begin miscompares++; $display("FAIL timer_ti_early got %b exp 0", rdata[30]); end
      step();
      vectors++;
      if ({rdata[30], rdata[15], int_req} !== 3'b110) begin
         miscompares++; $display("FAIL timer_match got %b exp 110", {rdata[30], rdata[15], int_req});
      end
      raddr = 5'd9; #1;
      vectors++;
      if (rdata !== 32'd5) begin miscompares++; $display("FAIL timer_count10 got %h exp 5", rdata); end
      step();
      vectors++;
      if (int_req !== 1'b1) begin miscompares++; $display("FAIL timer_int_req got %b exp 1", int_req); end
      wr_reg(5'd11, 32'd1000);
      raddr = 5'd13; #1;
      vectors++;
      if ({rdata[30], rdata[15]} !== 2'b00) begin miscompares++; $display("FAIL timer_ti_clear got %b exp 00", {rdata[30], rdata[15]}); end
      step();
      vectors++;
      if (int_req !== 1'b0) begin miscompares++; $display("FAIL timer_int_drop got %b exp 0", int_req); end
   endtask

   task automatic test_exception();
      idle(); exc_valid = 1'b1; exc_bd = 1'b1; exc_pc = 32'hBFC0_0104;
      exc_code = 5'd4; exc_badvaddr = 32'h0000_1233;
      step(); idle();
      raddr = 5'd14; #1;
      vectors++;
      if ({rdata, epc_out, status_exl} !== {32'hBFC0_0100, 32'hBFC0_0100, 1'b1}) begin
         miscompares++; $display("FAIL exc_epc got %h %h %b exp bfc00100 bfc00100 1", rdata, epc_out, status_exl);
      end
      raddr = 5'd8; #1;
      vectors++;
      if (rdata !== 32'h0000_1233) begin miscompares++; $display("FAIL exc_badvaddr got %h exp 00001233", rdata); end
      raddr = 5'd13; #1;
      vectors++;
      if ({rdata[31], rdata[6:2]} !== {1'b1, 5'd4}) begin miscompares++; $display("FAIL exc_cause got %h exp BD=1 code=4", rdata); end
      exc_valid = 1'b1; exc_bd = 1'b0; exc_pc = 32'h0000_4000; exc_code = 5'h0A; exc_badvaddr = 32'h5555;
      step(); idle();
      vectors++;
      if ({rdata[31], rdata[6:2], epc_out, status_exl} !== {1'b1, 5'h0A, 32'hBFC0_0100, 1'b1}) begin
         miscompares++; $display("FAIL exc_nested got %h %h %b exp BD=1 code=0a bfc00100 1", rdata, epc_out, status_exl);
      end
      raddr = 5'd8; #1;
      vectors++;
      if (rdata !== 32'h0000_1233) begin miscompares++; $display("FAIL exc_badv_hold got %h exp 00001233", rdata); end
      eret = 1'b1;
      step(); idle();
      vectors++;
      if ({status_exl, epc_out} !== {1'b0, 32'hBFC0_0100}) begin
         miscompares++; $display("FAIL eret got %b %h exp 0 bfc00100", status_exl, epc_out);
      end
   endtask

   task automatic test_status_cause();
      wr_reg(5'd12, 32'hFFFF_FFFF);
      raddr = 5'd12; #1;
      vectors++;
      if (rdata !== 32'h0040_FF03) begin miscompares++; $display("FAIL status_mask got %h exp 0040ff03", rdata); end
      wr_reg(5'd13, 32'hFFFF_FFFF);
      raddr = 5'd13; #1;
      vectors++;
      if (rdata !== 32'h8000_0328) begin miscompares++; $display("FAIL cause_mask got %h exp 80000328", rdata); end
      step();
      vectors++;
      if (int_req !== 1'b0) begin miscompares++; $display("FAIL swint_exl got %b exp 0", int_req); end
      eret = 1'b1; step(); idle();
      vectors++;
      if ({status_exl, int_req} !== 2'b00) begin miscompares++; $display("FAIL swint_eret got %b exp 00", {status_exl, int_req}); end
      step();
      vectors++;
      if (int_req !== 1'b1) begin miscompares++; $display("FAIL swint_req got %b exp 1", int_req); end
      wr_reg(5'd13, 32'd0);
      wr_reg(5'd12, 32'd0);
   endtask

   task automatic test_back_to_back();
      idle(); exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_2000; exc_bd = 1'b0;
      eret = 1'b1; mtc0_we = 1'b1; waddr = 5'd9; wdata = 32'h0000_1234;
      step(); idle();
      raddr = 5'd9; #1;
      vectors++;
      if ({status_exl, epc_out} !== {1'b1, 32'h0000_2000}) begin
         miscompares++; $display("FAIL prio_exc got %b %h exp 1 00002000", status_exl, epc_out);
      end
      vectors++;
      if (rdata !== m_count || rdata === 32'h0000_1234) begin
         miscompares++; $display("FAIL prio_count got %h exp %h", rdata, m_count);
      end
      eret = 1'b1; step(); idle();
      wr_reg(5'd9, 32'hFFFF_FFFF);
      step();
      vectors++;
      if (rdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_hold got %h exp ffffffff", rdata); end
      step();
      vectors++;
      if (rdata !== 32'd0) begin miscompares++; $display("FAIL wrap got %h exp 00000000", rdata); end
   endtask

   task automatic test_hwint();
      raddr = 5'd13; hw_int = 5'b00001; #1;
      vectors++;
      if (rdata[10] !== 1'b0) begin miscompares++; $display("FAIL hw_pre got %b exp 0", rdata[10]); end
      step(); hw_int = '0;
      vectors++;
      if (rdata[14:10] !== 5'b00001) begin miscompares++; $display("FAIL hw_ip2 got %b exp 00001", rdata[14:10]); end
      step();
      vectors++;
      if (rdata[14:10] !== 5'b00000) begin miscompares++; $display("FAIL hw_fall got %b exp 00000", rdata[14:10]); end
   endtask

   task automatic test_async_reset();
      wr_reg(5'd12, 32'h0000_8001);
      wr_reg(5'd11, 32'd2);
      wr_reg(5'd9, 32'd0);
      for (int i = 0; i < 5; i++) step();
      vectors++;
      if (int_req !== 1'b1) begin miscompares++; $display("FAIL areset_pre got %b exp 1", int_req); end
      raddr = 5'd9;
      #2; rst = 1'b1; #1;
      vectors++;
      if ({int_req, status_exl, epc_out, rdata} !== 66'd0) begin
         miscompares++; $display("FAIL areset_out got %b %b %h %h exp all 0", int_req, status_exl, epc_out, rdata);
      end
      raddr = 5'd13; #1;
      vectors++;
      if (rdata !== 32'd0) begin miscompares++; $display("FAIL areset_cause got %h exp 0", rdata); end
      raddr = 5'd12; #1;
      vectors++;
      if (rdata !== 32'h0040_0000) begin miscompares++; $display("FAIL areset_status got %h exp 00400000", rdata); end
      #1; rst = 1'b0; model_reset();
   endtask

   task automatic test_random();
      logic [4:0] waddrs [0:8];
      int r;
      waddrs[0] = 5'd9;  waddrs[1] = 5'd11; waddrs[2] = 5'd12; waddrs[3] = 5'd13;
      waddrs[4] = 5'd14; waddrs[5] = 5'd0;  waddrs[6] = 5'd3;  waddrs[7] = 5'd20;
      waddrs[8] = 5'd31;
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         mtc0_we      = (r < 45);
         waddr        = waddrs[$urandom_range(0, 8)];
         wdata        = $urandom;
         if (waddr == 5'd11) wdata = m_count + $urandom_range(1, 6);
         if (waddr == 5'd12 && $urandom_range(0, 1) == 1) wdata = wdata & 32'hFFFF_FFFD;
         exc_valid    = ($urandom_range(0, 9) == 0);
         eret         = ($urandom_range(0, 7) == 0);
         exc_code     = $urandom_range(0, 7);
         exc_bd       = $urandom_range(0, 1);
         exc_pc       = $urandom;
         exc_badvaddr = $urandom;
         hw_int       = $urandom_range(0, 31);
         raddr        = $urandom_range(0, 31);
         #1;
         vectors++;
         if (rdata !== m_read(raddr)) begin
            miscompares++; $display("FAIL rand_rdata cyc %0d addr %0d got %h exp %h", i, raddr, rdata, m_read(raddr));
         end
         step();
         vectors++;
         if ({epc_out, status_exl, int_req} !== {m_epc, m_status[1], m_int}) begin
            miscompares++; $display("FAIL rand_out cyc %0d got %h %b %b exp %h %b %b", i, epc_out, status_exl, int_req, m_epc, m_status[1], m_int);
         end
      end
      idle(); hw_int = '0;
   endtask

   initial begin
      test_reset();
      test_timer();
      test_exception();
      test_status_cause();
      test_back_to_back();
      test_hwint();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
